// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcodes, responder FSM states and burst helper for tl_sram.
package tl_pkg;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUT  = 3'd1,
    ST_RD   = 3'd2,
    ST_DATA = 3'd3,
    ST_ACK  = 3'd4
  } state_e;

  // Index of the final beat (beats-1); oversize requests are clamped to a full line.
  function automatic logic [2:0] beats_last(input logic [2:0] size);
    logic [4:0] n;
    n = (size > 3'd3) ? (5'd1 << (size - 3'd3)) : 5'd1;
    beats_last = (n > 5'd8) ? 3'd7 : 3'(n - 5'd1);
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// Single-port DEPTH x 64 SRAM with byte write enables and a registered read port.
module sram_1rw #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wmask_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // Contents and read register are deliberately left unreset, like a real macro.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 8; b++) begin
        if (wmask_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tl_sram.sv
// TileLink-UL SRAM responder, single outstanding request, bursts up to 8 x 64-bit beats.
// Define TL_SRAM_ERR_EN to deny out-of-range, region-crossing, unknown-opcode and oversize requests.
module tl_sram
  import tl_pkg::*;
#(
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
  parameter int          DEPTH = 4096,
  parameter int          SRC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [2:0]       a_opcode_i,
  input  logic [2:0]       a_size_i,
  input  logic [SRC_W-1:0] a_source_i,
  input  logic [63:0]      a_address_i,
  input  logic [7:0]       a_mask_i,
  input  logic [63:0]      a_data_i,
  output logic             d_valid_o,
  input  logic             d_ready_i,
  output logic [2:0]       d_opcode_o,
  output logic [2:0]       d_size_o,
  output logic [SRC_W-1:0] d_source_o,
  output logic [63:0]      d_data_o,
  output logic             d_denied_o,
  output logic [2:0]       state_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Handshakes: a beat transfers on a clock edge where valid && ready; a valid
  // holder keeps every payload field stable until that edge.

  state_e             state_q, state_d;
  logic [2:0]         size_q, size_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         beat_q, beat_d;
  logic [2:0]         last_q, last_d;
  logic               den_q, den_d;

  logic [63:0]        a_off;
  logic [2:0]         a_last;
  logic [IDX_W-1:0]   a_idx;
  logic               a_is_get, a_is_put, a_den;
  logic               a_fire;
  logic               mem_we, mem_re;
  logic [IDX_W-1:0]   mem_addr;
  logic [63:0]        mem_rdata;
  logic               unused_addr_bits;

  assign a_off    = a_address_i - BASE;
  assign a_last   = beats_last(a_size_i);
  // Bits below the burst alignment are dropped so a burst always starts line-aligned.
  assign a_idx    = a_off[IDX_W+2:3] & ~IDX_W'(a_last);
  assign a_is_get = (a_opcode_i == TL_GET);
  assign a_is_put = (a_opcode_i == TL_PUT_FULL) || (a_opcode_i == TL_PUT_PARTIAL);
  assign a_fire   = a_valid_i && a_ready_o;
  assign unused_addr_bits = ^{a_off[63:IDX_W+3], a_off[2:0]};

`ifdef TL_SRAM_ERR_EN
  logic [IDX_W:0] a_end;
  assign a_end = {1'b0, a_idx} + (IDX_W+1)'(a_last);
  assign a_den = (a_address_i < BASE)
              || (a_off >= 64'(DEPTH) * 64'd8)
              || (a_end > (IDX_W+1)'(DEPTH - 1))
              || !(a_is_get || a_is_put)
              || (a_size_i > 3'd6);
`else
  assign a_den = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      size_q  <= '0;
      src_q   <= '0;
      idx_q   <= '0;
      beat_q  <= '0;
      last_q  <= '0;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      src_q   <= src_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      den_q   <= den_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    src_d   = src_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    last_d  = last_q;
    den_d   = den_q;
    unique case (state_q)
      ST_IDLE: begin
        if (a_fire) begin
          size_d = a_size_i;
          src_d  = a_source_i;
          last_d = a_last;
          den_d  = a_den;
          idx_d  = a_idx;
          beat_d = 3'd0;
          if (a_is_get) begin
            state_d = ST_RD;
          end else if (a_is_put && a_last != 3'd0) begin
            // Beat 0 is written this cycle, so the burst continues at the next word.
            idx_d   = a_idx + 1'b1;
            beat_d  = 3'd1;
            state_d = ST_PUT;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_PUT: begin
        if (a_fire) begin
          idx_d  = idx_q + 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == last_q) state_d = ST_ACK;
        end
      end
      ST_RD: state_d = ST_DATA;
      ST_DATA: begin
        if (d_ready_i) begin
          if (beat_q == last_q) begin
            beat_d  = 3'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            beat_d  = beat_q + 3'd1;
            state_d = ST_RD;
          end
        end
      end
      ST_ACK: begin
        if (d_ready_i) begin
          beat_d  = 3'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_ready_o  = (state_q == ST_IDLE) || (state_q == ST_PUT);
    d_valid_o  = (state_q == ST_DATA) || (state_q == ST_ACK);
    d_opcode_o = (state_q == ST_DATA) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    d_size_o   = d_valid_o ? size_q : 3'd0;
    d_source_o = d_valid_o ? src_q : '0;
    d_data_o   = ((state_q == ST_DATA) && !den_q) ? mem_rdata : 64'd0;
    d_denied_o = d_valid_o && den_q;
    mem_we     = ((state_q == ST_IDLE) && a_fire && a_is_put && !a_den)
              || ((state_q == ST_PUT) && a_fire && !den_q);
    mem_re     = (state_q == ST_RD);
    mem_addr   = (state_q == ST_IDLE) ? a_idx : idx_q;
    state_o    = state_q;
  end

  sram_1rw #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_sram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wmask_i (a_mask_i),
    .wdata_i (a_data_i),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_tl_sram.sv
// Directed self-checking bench for tl_sram; expectations follow TL_SRAM_ERR_EN when defined.
module tb_tl_sram;
  import tl_pkg::*;

  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          SRC_W = 4;

  logic             clk, rst_n;
  logic             a_valid, a_ready;
  logic [2:0]       a_opcode, a_size;
  logic [SRC_W-1:0] a_source;
  logic [63:0]      a_address, a_data;
  logic [7:0]       a_mask;
  logic             d_valid, d_ready;
  logic [2:0]       d_opcode, d_size;
  logic [SRC_W-1:0] d_source;
  logic [63:0]      d_data;
  logic             d_denied;
  logic [2:0]       state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cyc  = 0;

  tl_sram #(.BASE(BASE), .DEPTH(DEPTH), .SRC_W(SRC_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_valid_i   (a_valid),
    .a_ready_o   (a_ready),
    .a_opcode_i  (a_opcode),
    .a_size_i    (a_size),
    .a_source_i  (a_source),
    .a_address_i (a_address),
    .a_mask_i    (a_mask),
    .a_data_i    (a_data),
    .d_valid_o   (d_valid),
    .d_ready_i   (d_ready),
    .d_opcode_o  (d_opcode),
    .d_size_o    (d_size),
    .d_source_o  (d_source),
    .d_data_o    (d_data),
    .d_denied_o  (d_denied),
    .state_o     (state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one A beat starting at a negedge; returns at the negedge after the handshake.
  task automatic a_send(input string tag, input logic [2:0] op, input logic [2:0] size,
                        input logic [SRC_W-1:0] src, input logic [63:0] addr,
                        input logic [7:0] mask, input logic [63:0] data);
    bit done;
    done      = 0;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = size;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    for (int i = 0; i < 20 && !done; i++) begin
      if (a_ready) begin
        @(posedge clk);
        @(negedge clk);
        hs_cyc = cyc;
        done   = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check({tag, "_a_ready_timeout"}, a_ready, 1'b1);
    a_valid = 1'b0;
  endtask

  task automatic wait_dvalid(input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (d_valid) ok = 1;
      else @(negedge clk);
    end
    if (!ok) check({tag, "_d_valid_timeout"}, d_valid, 1'b1);
  endtask

  // Receive one D beat; stall cycles hold d_ready low and then re-check the held fields.
  task automatic d_recv(input string tag, input logic [2:0] op, input logic [SRC_W-1:0] src,
                        input logic [2:0] size, input logic [63:0] data, input logic den,
                        input int stall, input int exp_lat);
    bit ok;
    d_ready = 1'b0;
    wait_dvalid(tag, ok);
    if (!ok) return;
    if (exp_lat != 0) check({tag, "_latency"}, 64'(cyc - hs_cyc + 1), 64'(exp_lat));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_held_valid"}, d_valid, 1'b1);
      check({tag, "_a_ready_busy"}, a_ready, 1'b0);
    end
    check({tag, "_opcode"}, d_opcode, op);
    check({tag, "_source"}, d_source, src);
    check({tag, "_size"}, d_size, size);
    check({tag, "_data"}, d_data, data);
    check({tag, "_denied"}, d_denied, den);
    d_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] ovf_data;
    logic        ovf_den;
    logic        unk_den;
    bit          ok;

`ifdef TL_SRAM_ERR_EN
    ovf_data = 64'd0;
    ovf_den  = 1'b1;
    unk_den  = 1'b1;
`else
    ovf_data = 64'h0123_4567_89AB_CDEF;
    ovf_den  = 1'b0;
    unk_den  = 1'b0;
`endif

    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0; a_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_ready", a_ready, 1'b1);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_d_fields", {d_opcode, d_size, d_source, d_denied}, '0);
    check("rst_d_data", d_data, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_no_d", d_valid, 1'b0);
    end

    // Full put then readback
    a_send("put_full", TL_PUT_FULL, 3'd3, 4'd2, BASE + 64'd8, 8'hFF, 64'hDEAD_BEEF_0123_4567);
    d_recv("put_full_ack", TL_ACCESS_ACK, 4'd2, 3'd3, 64'd0, 1'b0, 0, 1);
    a_send("get1", TL_GET, 3'd3, 4'd5, BASE + 64'd8, 8'hFF, 64'd0);
    d_recv("get1_d", TL_ACCESS_ACK_DATA, 4'd5, 3'd3, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 2);

    // Partial put over the low half
    a_send("put_part", TL_PUT_PARTIAL, 3'd3, 4'd1, BASE + 64'd8, 8'h0F, 64'hFFFF_FFFF_AAAA_AAAA);
    d_recv("put_part_ack", TL_ACCESS_ACK, 4'd1, 3'd3, 64'd0, 1'b0, 0, 1);
    a_send("get2", TL_GET, 3'd3, 4'd3, BASE + 64'd8, 8'hFF, 64'd0);
    d_recv("get2_d", TL_ACCESS_ACK_DATA, 4'd3, 3'd3, 64'hDEAD_BEEF_AAAA_AAAA, 1'b0, 0, 2);

    // 8-beat put and stalled 8-beat get
    for (int i = 0; i < 8; i++)
      a_send("burst_put", TL_PUT_FULL, 3'd6, 4'd4, BASE + 64'd64 + 64'(i * 8), 8'hFF, 64'(i));
    d_recv("burst_put_ack", TL_ACCESS_ACK, 4'd4, 3'd6, 64'd0, 1'b0, 0, 1);
    a_send("burst_get", TL_GET, 3'd6, 4'd6, BASE + 64'd64, 8'hFF, 64'd0);
    for (int i = 0; i < 8; i++)
      d_recv($sformatf("burst_get_b%0d", i), TL_ACCESS_ACK_DATA, 4'd6, 3'd6, 64'(i), 1'b0, 1,
             (i == 0) ? 2 : 0);
    check("burst_after_a_ready", a_ready, 1'b1);

    // Past the end of the region
    a_send("put_w0", TL_PUT_FULL, 3'd3, 4'd7, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF);
    d_recv("put_w0_ack", TL_ACCESS_ACK, 4'd7, 3'd3, 64'd0, 1'b0, 0, 1);
    a_send("get_ovf", TL_GET, 3'd3, 4'd8, BASE + 64'(DEPTH) * 64'd8, 8'hFF, 64'd0);
    d_recv("get_ovf_d", TL_ACCESS_ACK_DATA, 4'd8, 3'd3, ovf_data, ovf_den, 0, 2);

    // Unknown opcode
    a_send("unk_op", 3'd3, 3'd3, 4'd9, BASE + 64'd16, 8'hFF, 64'hFFFF);
    d_recv("unk_op_ack", TL_ACCESS_ACK, 4'd9, 3'd3, 64'd0, unk_den, 0, 1);

    // Reset during beat 3 of a burst get
    a_send("rst_get", TL_GET, 3'd6, 4'd11, BASE + 64'd64, 8'hFF, 64'd0);
    for (int i = 0; i < 3; i++)
      d_recv($sformatf("rst_get_b%0d", i), TL_ACCESS_ACK_DATA, 4'd11, 3'd6, 64'(i), 1'b0, 0, 0);
    wait_dvalid("rst_get_b3", ok);
    rst_n = 1'b0;
    #1;
    check("rst_async_d_valid", d_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_a_ready", a_ready, 1'b1);
    check("rst_rel_d_valid", d_valid, 1'b0);
    a_send("post_rst_get", TL_GET, 3'd3, 4'd12, BASE + 64'd8, 8'hFF, 64'd0);
    d_recv("post_rst_get_d", TL_ACCESS_ACK_DATA, 4'd12, 3'd3, 64'hDEAD_BEEF_AAAA_AAAA, 1'b0, 0, 2);
    a_send("post_rst_get3", TL_GET, 3'd3, 4'd13, BASE + 64'd88, 8'hFF, 64'd0);
    d_recv("post_rst_get3_d", TL_ACCESS_ACK_DATA, 4'd13, 3'd3, 64'd3, 1'b0, 0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
